// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
// FSM state encoding and add_sub mode values.
package add_sub_arbiter_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_arbiter_add_sub.sv
// add_sub: combinational adder/subtractor, {Cout,Sum} = a + (mode ? ~b+1 : b).
// Ports: a, b operands; mode 0=add 1=sub; Sum result; Cout carry (no-borrow on sub).
module add_sub
  import add_sub_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  logic [WIDTH-1:0] bx;

  assign bx = (mode == MODE_SUB) ? ~b : b;

  // mode doubles as the +1 carry-in for two's-complement subtract
  assign {Cout, Sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, mode};

endmodule

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin share of one add_sub between requesters 0/1.
// Ports: req0_*/req1_* valid/ready ops, res_* tagged result held until res_ready.
module add_sub_arbiter
  import add_sub_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  input  logic             res_ready
);

  state_t           state, state_nx;
  logic             ptr, ptr_nx;
  logic             g0, g1, ld_res;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_mode, op_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a    (op_a),
    .b    (op_b),
    .mode (op_mode),
    .Sum  (sum),
    .Cout (cout)
  );

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    g0       = 1'b0;
    g1       = 1'b0;
    ld_res   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // ptr names the requester preferred on contention
        if (req0_valid && (!req1_valid || !ptr)) g0 = 1'b1;
        else if (req1_valid)                     g1 = 1'b1;
        if (g0 || g1) begin
          state_nx = ST_EXEC;
          ptr_nx   = g0;
        end
      end
      ST_EXEC: begin
        ld_res   = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        if (res_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign req0_ready = g0 & ~rst;
  assign req1_ready = g1 & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_mode   <= 1'b0;
      op_id     <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      if (g0 || g1) begin
        op_a    <= g1 ? req1_a    : req0_a;
        op_b    <= g1 ? req1_b    : req0_b;
        op_mode <= g1 ? req1_mode : req0_mode;
        op_id   <= g1;
      end
      if (ld_res) begin
        res_valid <= 1'b1;
        res_sum   <= sum;
        res_cout  <= cout;
        res_id    <= op_id;
      end else if (state == ST_RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: directed scenarios plus random traffic.
// A transaction-level model predicts grants, latency and results.
module tb_add_sub_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = '0;
  logic [3:0] req0_b = '0;
  logic       req0_mode = 1'b0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = '0;
  logic [3:0] req1_b = '0;
  logic       req1_mode = 1'b0;
  logic       req1_ready;
  logic       res_valid;
  logic [3:0] res_sum;
  logic       res_cout;
  logic       res_id;
  logic       res_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_sub_arbiter #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  // model: one op in flight at most; result visible from the
  // second cycle after its grant until consumed
  bit         m_busy = 0;
  int         m_age = 0;
  bit         m_ptr = 0;
  logic [5:0] m_exp = '0;
  bit         s_g0, s_g1, s_rr, s_rst;
  logic [3:0] s_a0, s_b0, s_a1, s_b1;
  logic       s_m0, s_m1;
  bit         o_r0, o_r1;
  int         glog[$];
  logic [5:0] dlog[$];

  function automatic logic [4:0] golden(logic [3:0] a, logic [3:0] b,
                                        logic m);
    int r;
    r = m ? int'(a) - int'(b) + 16 : int'(a) + int'(b);
    return 5'(r);
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit er0, er1, erv;
    er0 = !rst && !m_busy && req0_valid && (!req1_valid || !m_ptr);
    er1 = !rst && !m_busy && req1_valid && (!req0_valid || m_ptr);
    erv = m_busy && m_age >= 1;
    chk("req0_ready", 8'(req0_ready), 8'(er0));
    chk("req1_ready", 8'(req1_ready), 8'(er1));
    chk("res_valid", 8'(res_valid), 8'(erv));
    if (erv)
      chk("res_id_cout_sum", 8'({res_id, res_cout, res_sum}), 8'(m_exp));
    o_r0 = req0_ready;
    o_r1 = req1_ready;
    if (req0_ready) glog.push_back(0);
    if (req1_ready) glog.push_back(1);
    if (res_valid && res_ready && !rst)
      dlog.push_back({res_id, res_cout, res_sum});
    s_g0 = er0; s_g1 = er1; s_rr = res_ready; s_rst = rst;
    s_a0 = req0_a; s_b0 = req0_b; s_m0 = req0_mode;
    s_a1 = req1_a; s_b1 = req1_b; s_m1 = req1_mode;
  endtask

  task automatic model_edge();
    if (s_rst) begin
      m_busy = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      if (s_g0 || s_g1) begin
        m_busy = 1;
        m_age  = 0;
        m_ptr  = s_g0;
        m_exp  = s_g1 ? {1'b1, golden(s_a1, s_b1, s_m1)}
                      : {1'b0, golden(s_a0, s_b0, s_m0)};
      end
    end else if (m_age >= 1 && s_rr) begin
      m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic cyc();
    #2;
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic op0(logic [3:0] a, logic [3:0] b, logic m);
    req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m;
    cyc();
    req0_valid = 0;
    cyc();
    cyc();
  endtask

  int g, d, n;
  logic [5:0] held;

  initial begin
    // reset
    @(posedge clk); #1;
    cyc();
    chk("rst_res_valid", 8'(res_valid), 8'd0);
    chk("rst_res_sum", 8'(res_sum), 8'd0);
    chk("rst_res_cout", 8'(res_cout), 8'd0);
    chk("rst_res_id", 8'(res_id), 8'd0);
    chk("rst_ready0", 8'(req0_ready), 8'd0);
    chk("rst_ready1", 8'(req1_ready), 8'd0);
    rst = 0;

    // single requester add/sub
    res_ready = 1;
    g = glog.size(); d = dlog.size();
    op0(4'b0110, 4'b0010, 1'b0);
    op0(4'b1001, 4'b0011, 1'b1);
    op0(4'b1111, 4'b0001, 1'b0);
    op0(4'b1001, 4'b1100, 1'b1);
    chk("t1_grants", 8'(glog.size() - g), 8'd4);
    chk("t1_results", 8'(dlog.size() - d), 8'd4);
    if (dlog.size() >= d + 4) begin
      chk("t1_r0", 8'(dlog[d]),     8'b0_0_1000);
      chk("t1_r1", 8'(dlog[d + 1]), 8'b0_1_0110);
      chk("t1_r2", 8'(dlog[d + 2]), 8'b0_1_0000);
      chk("t1_r3", 8'(dlog[d + 3]), 8'b0_0_1101);
    end

    // contention from reset
    rst = 1;
    req0_valid = 1; req0_a = 4'b0011; req0_b = 4'b0001; req0_mode = 0;
    req1_valid = 1; req1_a = 4'b0101; req1_b = 4'b0010; req1_mode = 1;
    cyc();
    rst = 0;
    g = glog.size(); d = dlog.size();
    for (int i = 0; i < 24; i++) cyc();
    chk("t2_grants", 8'(glog.size() - g), 8'd8);
    chk("t2_results", 8'(dlog.size() - d), 8'd8);
    for (int i = 0; i < 8; i++) begin
      if (glog.size() > g + i)
        chk("t2_grant_order", 8'(glog[g + i]), 8'(i % 2));
      if (dlog.size() > d + i)
        chk("t2_result", 8'(dlog[d + i]),
            (i % 2 == 0) ? 8'b0_0_0100 : 8'b1_1_0011);
    end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 3; i++) cyc();

    // backpressure
    res_ready = 0;
    req1_valid = 1; req1_a = 4'd7; req1_b = 4'd9; req1_mode = 1;
    cyc();
    req1_valid = 0;
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd3; req0_mode = 0;
    cyc();
    held = {res_id, res_cout, res_sum};
    for (int i = 0; i < 5; i++) cyc();
    chk("t4_held", 8'({res_id, res_cout, res_sum}), 8'(held));
    chk("t4_held_val", 8'(held), 8'b1_0_1110);
    res_ready = 1;
    cyc();
    cyc();
    chk("t4_next_grant", 8'(o_r0), 8'd1);
    req0_valid = 0;
    cyc();
    cyc();

    // reset mid-operation
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_mode = 0;
    cyc();
    req0_valid = 0;
    d = dlog.size();
    rst = 1;
    cyc();
    rst = 0;
    chk("t5_exec_rv", 8'(res_valid), 8'd0);
    req0_valid = 1; req1_valid = 1;
    cyc();
    chk("t5_exec_first", 8'(o_r0), 8'd1);
    req0_valid = 0;
    res_ready = 0;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("t5_resp_rv", 8'(res_valid), 8'd0);
    chk("t5_no_result", 8'(dlog.size() - d), 8'd0);
    res_ready = 1;
    req0_valid = 1;
    cyc();
    chk("t5_resp_first", 8'(o_r0), 8'd1);
    req0_valid = 0;
    cyc();
    cyc();
    cyc();
    cyc();
    req1_valid = 0;
    for (int i = 0; i < 3; i++) cyc();

    // idle and spurious handshakes
    res_ready = 1;
    d = dlog.size();
    for (int i = 0; i < 10; i++) cyc();
    chk("t6_idle", 8'(dlog.size() - d), 8'd0);
    g = glog.size();
    req0_valid = 1; req0_a = 4'd4; req0_b = 4'd4; req0_mode = 1;
    cyc();
    req0_valid = 0;
    req1_valid = 1; req1_a = 4'd8; req1_b = 4'd8; req1_mode = 0;
    cyc();
    req1_valid = 0;
    cyc();
    cyc();
    cyc();
    chk("t6_grants", 8'(glog.size() - g), 8'd1);
    chk("t6_results", 8'(dlog.size() - d), 8'd1);
    if (dlog.size() > d)
      chk("t6_result", 8'(dlog[d]), 8'b0_1_0000);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (!req0_valid || o_r0) begin
        req0_valid = 1'($urandom);
        req0_a = 4'($urandom); req0_b = 4'($urandom);
        req0_mode = 1'($urandom);
      end else if ($urandom_range(15) == 0) begin
        req0_valid = 0;
      end
      if (!req1_valid || o_r1) begin
        req1_valid = 1'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom);
        req1_mode = 1'($urandom);
      end else if ($urandom_range(15) == 0) begin
        req1_valid = 0;
      end
      res_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(63) == 0);
      cyc();
    end
    n = dlog.size();
    chk("rand_progress", 8'(n > 40), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
